vga_timing_monitor: RTL and testbench

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_edge_det.sv | 23 ++
 rtl/vga_timing_monitor.sv | 159 +++++++++++++++
 tb/tb_vga_timing_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants and the timing-monitor FSM encoding.
package vga_pkg;

  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_H_ACT   = 640;
  localparam int VGA_V_ACT   = 480;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;

  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ST_SEARCH = 2'd0;
  localparam mon_state_t ST_TRAIN  = 2'd1;
  localparam mon_state_t ST_LOCKED = 2'd2;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Falling-edge detector on a signal sampled only when p_tick is high.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic p_tick,
  input  logic din,
  output logic fall
);

  logic prev_reg;

  // Idle-high previous sample so a line already low at reset release counts as a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= 1'b1;
    end else if (p_tick) begin
      prev_reg <= din;
    end
  end

  assign fall = p_tick & prev_reg & ~din;

endmodule

// File: rtl/vga_timing_monitor.sv
// Recovers pixel position from a VGA sync stream, verifies its timing and
// accumulates a per-frame RGB checksum once the stream is locked.
module vga_timing_monitor
  import vga_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int H_ACT   = VGA_H_ACT,
  parameter int V_ACT   = VGA_V_ACT,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        video_on,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        err_clr,
  output logic        locked,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic        h_err,
  output logic        v_err,
  output logic        de_err
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] H_ACT_W = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W = 10'(V_ACT);

  logic        hs_fall, vs_fall;
  logic [9:0]  hcnt_reg, vcnt_reg, hcnt_next, vcnt_next;
  logic [9:0]  h_off, v_off, x_reg, y_reg;
  mon_state_t  state_reg, state_next;
  logic        in_lock, h_bad, v_bad, de_exp, pix_now, frame_ok, lose_lock;
  logic        h_set, v_set, de_set;
  logic        h_err_reg, v_err_reg, de_err_reg, pix_valid_reg, frame_done_reg;
  logic [9:0]  rgb_sum;
  logic [31:0] pix_sum, acc_reg, frame_sum_reg;

  vga_edge_det u_hs_edge (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick),
    .din    (hsync),
    .fall   (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick),
    .din    (vsync),
    .fall   (vs_fall)
  );

  // Position of the pixel being sampled on this tick.
  always_comb begin
    hcnt_next = hs_fall ? 10'd0 : sat_inc10(hcnt_reg);
    vcnt_next = vcnt_reg;
    if (vs_fall) begin
      vcnt_next = 10'd0;
    end else if (hs_fall) begin
      vcnt_next = vcnt_reg + 10'd1;
    end
  end

  assign h_off     = hcnt_next - H_START;
  assign v_off     = vcnt_next - V_START;
  assign de_exp    = (h_off < H_ACT_W) && (v_off < V_ACT_W);
  assign h_bad     = hs_fall && (hcnt_reg != H_LAST);
  assign v_bad     = vs_fall && (vcnt_reg != V_LAST);
  assign in_lock   = (state_reg == ST_LOCKED);
  assign lose_lock = in_lock && (h_bad || v_bad);
  assign frame_ok  = in_lock && vs_fall && !h_bad && !v_bad;
  assign pix_now   = p_tick && in_lock && de_exp;
  assign h_set     = in_lock && h_bad;
  assign v_set     = in_lock && v_bad;
  assign de_set    = p_tick && in_lock && (video_on != de_exp);
  assign rgb_sum   = {2'b00, red} + {2'b00, green} + {2'b00, blue};
  assign pix_sum   = 32'(rgb_sum);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SEARCH: if (vs_fall) state_next = ST_TRAIN;
      ST_TRAIN: begin
        if (h_bad || v_bad) state_next = ST_SEARCH;
        else if (vs_fall)   state_next = ST_LOCKED;
      end
      ST_LOCKED: if (h_bad || v_bad) state_next = ST_SEARCH;
      default:   state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_SEARCH;
      hcnt_reg       <= '0;
      vcnt_reg       <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      acc_reg        <= '0;
      frame_sum_reg  <= '0;
      pix_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      h_err_reg      <= 1'b0;
      v_err_reg      <= 1'b0;
      de_err_reg     <= 1'b0;
    end else begin
      pix_valid_reg  <= pix_now;
      frame_done_reg <= frame_ok;
      // A new error in the same cycle as err_clr survives the clear.
      h_err_reg      <= h_set  | (h_err_reg  & ~err_clr);
      v_err_reg      <= v_set  | (v_err_reg  & ~err_clr);
      de_err_reg     <= de_set | (de_err_reg & ~err_clr);
      if (p_tick) begin
        hcnt_reg  <= hcnt_next;
        vcnt_reg  <= vcnt_next;
        state_reg <= state_next;
        if (de_exp) begin
          x_reg <= h_off;
          y_reg <= v_off;
        end
        if (lose_lock || frame_ok) begin
          acc_reg <= '0;
        end else if (pix_now) begin
          acc_reg <= acc_reg + pix_sum;
        end
        if (frame_ok) begin
          frame_sum_reg <= acc_reg + (pix_now ? pix_sum : 32'd0);
        end
      end
    end
  end

  assign locked     = in_lock;
  assign x          = in_lock ? x_reg : 10'd0;
  assign y          = in_lock ? y_reg : 10'd0;
  assign pix_valid  = pix_valid_reg;
  assign frame_done = frame_done_reg;
  assign frame_sum  = frame_sum_reg;
  assign h_err      = h_err_reg;
  assign v_err      = v_err_reg;
  assign de_err     = de_err_reg;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized bench for vga_timing_monitor on a scaled-down raster, checked against a behavioural model.
module tb_vga_timing_monitor;

  localparam int HT = 40, VT = 20, HA = 24, VA = 12, HS = 6, HB = 4, VS = 2, VB = 3;
  localparam int M_SEARCH = 0, M_TRAIN = 1, M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        reset, p_tick, hsync, vsync, video_on, err_clr;
  logic [7:0]  red, green, blue;
  logic        locked, pix_valid, frame_done, h_err, v_err, de_err;
  logic [9:0]  x, y;
  logic [31:0] frame_sum;

  int total = 0, bad = 0;
  int fd_count = 0;
  logic [31:0] fd_last = '0;

  // Behavioural model state
  int          m_mode, m_col, m_row;
  bit          m_hprev, m_vprev;
  logic [9:0]  m_x, m_y;
  logic [31:0] m_acc, m_fs;
  bit          e_pix, e_fd, e_herr, e_verr, e_deerr;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT(HA), .V_ACT(VA),
    .H_SYNC(HS), .H_BP(HB), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .red(red), .green(green), .blue(blue), .err_clr(err_clr),
    .locked(locked), .x(x), .y(y), .pix_valid(pix_valid), .frame_done(frame_done),
    .frame_sum(frame_sum), .h_err(h_err), .v_err(v_err), .de_err(de_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [57:0] dut_outs();
    return {locked, x, y, pix_valid, frame_done, frame_sum, h_err, v_err, de_err};
  endfunction

  function automatic logic [57:0] model_outs();
    bit lk;
    lk = (m_mode == M_LOCKED);
    return {lk, lk ? m_x : 10'd0, lk ? m_y : 10'd0, e_pix, e_fd, m_fs, e_herr, e_verr, e_deerr};
  endfunction

  task automatic model_reset();
    m_mode = M_SEARCH; m_col = 0; m_row = 0; m_hprev = 1; m_vprev = 1;
    m_x = '0; m_y = '0; m_acc = '0; m_fs = '0;
    e_pix = 0; e_fd = 0; e_herr = 0; e_verr = 0; e_deerr = 0;
  endtask

  // One clock of the reference: line/frame lengths measured in ticks and lines.
  task automatic model_clock();
    bit hf, vf, h_ok, v_ok, act, hfail, vfail;
    e_pix = 0; e_fd = 0;
    if (reset) begin model_reset(); return; end
    if (err_clr) begin e_herr = 0; e_verr = 0; e_deerr = 0; end
    if (!p_tick) return;
    hf = m_hprev && !hsync;
    vf = m_vprev && !vsync;
    m_hprev = hsync; m_vprev = vsync;
    h_ok = (m_col == HT - 1);
    v_ok = (m_row == VT - 1);
    hfail = hf && !h_ok;
    vfail = vf && !v_ok;
    if (hf) m_col = 0; else if (m_col < 1023) m_col++;
    if (vf) m_row = 0; else if (hf) m_row = (m_row + 1) % 1024;
    act = (m_col >= HS + HB) && (m_col < HS + HB + HA) && (m_row >= VS + VB) && (m_row < VS + VB + VA);
    if (act) begin
      m_x = 10'(m_col - (HS + HB));
      m_y = 10'(m_row - (VS + VB));
    end
    if (m_mode == M_LOCKED) begin
      if (video_on != act) e_deerr = 1;
      if (act) begin
        e_pix = 1;
        m_acc = m_acc + 32'(red) + 32'(green) + 32'(blue);
      end
      if (hfail || vfail) begin
        if (hfail) e_herr = 1;
        if (vfail) e_verr = 1;
        m_acc = '0;
        m_mode = M_SEARCH;
      end else if (vf) begin
        m_fs = m_acc; e_fd = 1; m_acc = '0;
      end
    end else if (m_mode == M_TRAIN) begin
      if (hfail || vfail) m_mode = M_SEARCH;
      else if (vf) m_mode = M_LOCKED;
    end else if (vf) begin
      m_mode = M_TRAIN;
    end
  endtask

  task automatic tick_clock();
    @(posedge clk);
    model_clock();
    #1;
    chk("outs", 64'(dut_outs()), 64'(model_outs()));
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_last = frame_sum;
    end
  endtask

  task automatic pix(input bit hs, input bit vs, input bit de, input bit fixed, input bit clr);
    while ($urandom_range(0, 3) == 0) begin
      p_tick = 0; err_clr = 0;
      hsync = 1'($urandom); vsync = 1'($urandom); video_on = 1'($urandom);
      red = 8'($urandom);
      tick_clock();
    end
    p_tick = 1; hsync = hs; vsync = vs; video_on = de; err_clr = clr;
    if (fixed) {red, green, blue} = 24'h111111;
    else       {red, green, blue} = 24'($urandom);
    tick_clock();
    p_tick = 0; err_clr = 0;
  endtask

  task automatic reset_mid();
    #2 reset = 1;
    #1 chk("rst_async", 64'(dut_outs()), 64'd0);
    model_reset();
    tick_clock();
    tick_clock();
    @(negedge clk) reset = 0;
  endtask

  task automatic pulse_clr();
    p_tick = 0; err_clr = 1;
    tick_clock();
    err_clr = 0;
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int glitch_line,
                            input int rst_tick, input bit clr_on_fail, input bit fixed);
    int t, len;
    bit act, de, clr;
    t = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        act = (c >= HS + HB) && (c < HS + HB + HA) && (ln >= VS + VB) && (ln < VS + VB + VA);
        de  = act || (ln == glitch_line && c == HS + HB - 1);
        clr = clr_on_fail && (short_line >= 0) && (ln == short_line + 1) && (c == 0);
        if (t == rst_tick) reset_mid();
        pix(c >= HS, ln >= VS, de, fixed, clr);
        t++;
      end
    end
  endtask

  initial begin
    reset = 1; p_tick = 0; hsync = 1; vsync = 1; video_on = 0; err_clr = 0;
    red = '0; green = '0; blue = '0;
    model_reset();
    repeat (3) tick_clock();
    chk("reset_outs", 64'(dut_outs()), 64'd0);
    @(negedge clk) reset = 0;

    // Ideal stream with constant 0x11 colour
    send_frame(VT, -1, -1, -1, 0, 1);
    chk("unlocked_f1", 64'(locked), 64'd0);
    send_frame(VT, -1, -1, -1, 0, 1);
    chk("locked_f2", 64'(locked), 64'd1);
    send_frame(VT, -1, -1, -1, 0, 1);
    chk("first_fd_cnt", 64'(fd_count), 64'd1);
    chk("first_fd_sum", 64'(fd_last), 64'h3960);

    // Short line while locked
    send_frame(VT, 5, -1, -1, 0, 0);
    chk("short_herr", 64'(h_err), 64'd1);
    chk("short_unlock", 64'(locked), 64'd0);
    chk("short_fsum", 64'(frame_sum), 64'h3960);
    send_frame(VT, -1, -1, -1, 0, 0);
    send_frame(VT, -1, -1, -1, 0, 0);
    chk("relock_short", 64'(locked), 64'd1);

    // Video-enable glitch one column before the active window
    send_frame(VT, -1, 8, -1, 0, 0);
    chk("glitch_deerr", 64'(de_err), 64'd1);
    chk("glitch_locked", 64'(locked), 64'd1);

    // Frame one line short
    send_frame(VT - 1, -1, -1, -1, 0, 0);
    send_frame(VT, -1, -1, -1, 0, 0);
    chk("vshort_verr", 64'(v_err), 64'd1);
    chk("vshort_unlock", 64'(locked), 64'd0);
    send_frame(VT, -1, -1, -1, 0, 0);
    send_frame(VT, -1, -1, -1, 0, 0);
    chk("relock_v", 64'(locked), 64'd1);

    // Clear racing a fresh h error, then a lone clear
    pulse_clr();
    chk("flags_cleared", 64'({h_err, v_err, de_err}), 64'd0);
    send_frame(VT, 5, -1, -1, 1, 0);
    chk("clr_set_wins", 64'(h_err), 64'd1);
    pulse_clr();
    chk("clr_alone", 64'({h_err, v_err, de_err}), 64'd0);

    // Reset in the middle of a locked frame
    send_frame(VT, -1, -1, -1, 0, 0);
    send_frame(VT, -1, -1, -1, 0, 0);
    chk("locked_pre_rst", 64'(locked), 64'd1);
    send_frame(VT, -1, -1, 400, 0, 0);
    chk("rst_unlocked", 64'(locked), 64'd0);
    send_frame(VT, -1, -1, -1, 0, 0);
    chk("rst_train", 64'(locked), 64'd0);
    send_frame(VT, -1, -1, -1, 0, 0);
    chk("rst_relock", 64'(locked), 64'd1);

    repeat (4) tick_clock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
